datapath2: RTL

DATAPATH2 -- requirements
Module: datapath2

---
 rtl/datapath2.sv | 105 ++++++++++
 1 files changed

// File: rtl/datapath2.sv
// rtl/datapath2.sv - 16-entry register file with a 4-function ALU and registered flags
//
// Purpose:
//   Datapath slave of control2. Each cycle the control word selects two
//   operands from the register file (B may instead be the external i_data).
//   It also selects an ALU function and, optionally, a destination register
//   for the result.
//   The result, a zero flag and an A>B flag are registered every cycle and
//   returned to the controller one cycle later.
//
// Configuration:
//   DATAPATH2_SIGNED_EN  defined   -> mayor uses a two's-complement compare
//                        undefined -> mayor uses an unsigned compare (default)
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst_n     in   asynchronous active-low reset
//   i_ctrl    in   [14:13] cnt_alu, [12:9] slc_mux_a, [8:5] slc_mux_b,
//                  [4:1] slc_reg, [0] w
//   i_data    in   external operand, taken on B when slc_mux_b == 4'hF
//   mayor     out  registered (A > B)
//   bandera   out  registered (ALU result == 0)
//   o_result  out  registered ALU result
module datapath2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [14:0]   i_ctrl,
  input  logic [DW-1:0] i_data,
  output logic          mayor,
  output logic          bandera,
  output logic [DW-1:0] o_result
);

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  logic [1:0]    cnt_alu;
  logic [3:0]    slc_mux_a;
  logic [3:0]    slc_mux_b;
  logic [3:0]    slc_reg;
  logic          w;

  logic [DW-1:0] regs [16];
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          a_gt_b;

  assign cnt_alu   = i_ctrl[14:13];
  assign slc_mux_a = i_ctrl[12:9];
  assign slc_mux_b = i_ctrl[8:5];
  assign slc_reg   = i_ctrl[4:1];
  assign w         = i_ctrl[0];

  // Reads are taken straight from the array, so a write to the same index
  // in this cycle is only visible from the next cycle on.
  assign op_a = regs[slc_mux_a];
  assign op_b = (slc_mux_b == 4'hF) ? i_data : regs[slc_mux_b];

  // Carry and borrow fall off the top: results wrap modulo 2^DW.
  always_comb begin
    alu_res = op_a;
    case (cnt_alu)
      ALU_PASS: alu_res = op_a;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = op_a;
    endcase
  end

`ifdef DATAPATH2_SIGNED_EN
  assign a_gt_b = $signed(op_a) > $signed(op_b);
`else
  assign a_gt_b = op_a > op_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        regs[k] <= '0;
      end
    end else if (w) begin
      regs[slc_reg] <= alu_res;
    end
  end

  // Outputs follow the control word every cycle, independent of w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_result <= '0;
      bandera  <= 1'b0;
      mayor    <= 1'b0;
    end else begin
      o_result <= alu_res;
      bandera  <= (alu_res == '0);
      mayor    <= a_gt_b;
    end
  end

endmodule
